arb_mux_n: RTL and testbench

- N-channel registered arbitrating multiplexer with a valid/ready handshake on every input and on the output.
- Generational successor to the fixed 2-/3-way combinational selects. The select is no longer an input; it comes from an internal fixed-priority or round-robin arbiter.
- Sits between multiple producers (e.g. fetch/load/store request sources) and one shared consumer (memory/bus port).
- One output register stage gives full throughput with 1-cycle latency.

---
 rtl/arb_mux_n.sv | 121 ++++++++++++
 tb/tb_arb_mux_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_n.sv
// N-channel registered arbitrating mux: fixed-priority or round-robin grant,
// valid/ready on each input and on the output. Optional packet locking: ARB_MUX_LOCK_EN.
module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 In_Mode,
    input  logic [N-1:0]         In_Valid,
    input  logic [N*WIDTH-1:0]   In_Data,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N-1:0]         In_Last,
    output logic                 Out_Last,
`endif
    output logic [N-1:0]         In_Ready,
    output logic                 Out_Valid,
    output logic [WIDTH-1:0]     Out_Data,
    output logic [SEL_W-1:0]     Out_Sel,
    input  logic                 Out_Ready
);

    localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] grant_idx_s;
    logic [SEL_W-1:0] ptr_next_s;
    logic [N-1:0]     grant_s;
    logic             grant_any_s;
    logic             load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    int               idx_s;

`ifdef ARB_MUX_LOCK_EN
    logic             lock_r;
    logic [SEL_W-1:0] lock_ch_r;
`endif

    // Arbitration: scan from 0 (fixed priority) or from ptr (round-robin), first valid wins
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        idx_s       = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = (In_Mode ? int'(ptr_r) : 0) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!grant_any_s && In_Valid[idx_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = SEL_W'(idx_s);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
`ifdef ARB_MUX_LOCK_EN
        // A packet in progress owns the output until its last beat
        if (lock_r) begin
            grant_any_s = In_Valid[lock_ch_r];
            grant_idx_s = lock_ch_r;
        end else begin
            grant_any_s = grant_any_s;
        end
`endif
    end

    // Handshake and datapath select
    always_comb begin
        grant_s    = grant_any_s ? (ONE_HOT_BASE << grant_idx_s) : {N{1'b0}};
        load_s     = rstn & (~Out_Valid | Out_Ready);
        xfer_s     = grant_any_s & load_s;
        In_Ready   = grant_s & {N{load_s}};
        sel_data_s = In_Data[grant_idx_s*WIDTH +: WIDTH];
        ptr_next_s = (grant_idx_s == SEL_W'(N-1)) ? {SEL_W{1'b0}} : (grant_idx_s + SEL_W'(1));
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Sel   <= '0;
            ptr_r     <= '0;
        end else if (xfer_s) begin
            Out_Valid <= 1'b1;
            Out_Data  <= sel_data_s;
            Out_Sel   <= grant_idx_s;
`ifdef ARB_MUX_LOCK_EN
            ptr_r     <= In_Last[grant_idx_s] ? ptr_next_s : ptr_r;
`else
            ptr_r     <= ptr_next_s;
`endif
        end else if (load_s) begin
            Out_Valid <= 1'b0;
        end else begin
            Out_Valid <= Out_Valid;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    // Packet lock state and registered last flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_r    <= 1'b0;
            lock_ch_r <= '0;
            Out_Last  <= 1'b0;
        end else if (xfer_s) begin
            lock_r    <= ~In_Last[grant_idx_s];
            lock_ch_r <= grant_idx_s;
            Out_Last  <= In_Last[grant_idx_s];
        end else begin
            lock_r    <= lock_r;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed self-checking bench for arb_mux_n (N=4, WIDTH=32).
module tb_arb_mux_n;

    logic        clk;
    logic        rstn;
    logic        In_Mode;
    logic [3:0]  In_Valid;
    logic [127:0] In_Data;
    logic [3:0]  In_Ready;
    logic        Out_Valid;
    logic [31:0] Out_Data;
    logic [1:0]  Out_Sel;
    logic        Out_Ready;
`ifdef ARB_MUX_LOCK_EN
    logic [3:0]  In_Last;
    logic        Out_Last;
`endif

    int errors;
    int checks;

    arb_mux_n #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .In_Mode   (In_Mode),
        .In_Valid  (In_Valid),
        .In_Data   (In_Data),
`ifdef ARB_MUX_LOCK_EN
        .In_Last   (In_Last),
        .Out_Last  (Out_Last),
`endif
        .In_Ready  (In_Ready),
        .Out_Valid (Out_Valid),
        .Out_Data  (Out_Data),
        .Out_Sel   (Out_Sel),
        .Out_Ready (Out_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        In_Data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; In_Mode = 1'b0; In_Valid = 4'b1111; Out_Ready = 1'b1;
        set_data(32'h10, 32'h11, 32'h12, 32'h13);
        tick();
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", Out_Valid); end
        checks++; if (In_Ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got=%b exp=0000", In_Ready); end
        checks++; if (Out_Data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", Out_Data); end
        checks++; if (Out_Sel !== 2'd0) begin errors++; $display("FAIL rst_out_sel got=%0d exp=0", Out_Sel); end
        rstn = 1'b1;
        #1;
        checks++; if (In_Ready !== 4'b0001) begin errors++; $display("FAIL rel_in_ready got=%b exp=0001", In_Ready); end
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got=%0b exp=0", Out_Valid); end
        tick();
        checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid got=%0b exp=1", Out_Valid); end
        checks++; if (Out_Data !== 32'h10) begin errors++; $display("FAIL lat_out_data got=%h exp=10", Out_Data); end
    endtask

    task automatic test_fixed_priority();
        In_Mode = 1'b0; In_Valid = 4'b1010; Out_Ready = 1'b1;
        set_data(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (In_Ready !== 4'b0010) begin errors++; $display("FAIL fp_in_ready cyc=%0d got=%b exp=0010", c, In_Ready); end
            tick();
            checks++; if (Out_Sel !== 2'd1) begin errors++; $display("FAIL fp_out_sel cyc=%0d got=%0d exp=1", c, Out_Sel); end
            checks++; if (Out_Data !== 32'hB1) begin errors++; $display("FAIL fp_out_data cyc=%0d got=%h exp=b1", c, Out_Data); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
        do_reset();
        In_Mode = 1'b1; In_Valid = 4'b1111; Out_Ready = 1'b1;
        set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_sel  = k[1:0];
            exp_data = 32'hA0 + 32'(k[1:0]);
            checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid beat=%0d got=%0b exp=1", k, Out_Valid); end
            checks++; if (Out_Sel !== exp_sel) begin errors++; $display("FAIL rr_out_sel beat=%0d got=%0d exp=%0d", k, Out_Sel, exp_sel); end
            checks++; if (Out_Data !== exp_data) begin errors++; $display("FAIL rr_out_data beat=%0d got=%h exp=%h", k, Out_Data, exp_data); end
        end
    endtask

    task automatic test_backpressure();
        In_Mode = 1'b0; In_Valid = 4'b0001; Out_Ready = 1'b1;
        set_data(32'h55, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (Out_Data !== 32'h55) begin errors++; $display("FAIL bp_load got=%h exp=55", Out_Data); end
        Out_Ready = 1'b0; In_Valid = 4'b0110;
        set_data(32'h55, 32'h66, 32'h77, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (In_Ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0000", c, In_Ready); end
            tick();
            checks++; if (Out_Data !== 32'h55) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=55", c, Out_Data); end
            checks++; if (Out_Sel !== 2'd0) begin errors++; $display("FAIL bp_hold_sel cyc=%0d got=%0d exp=0", c, Out_Sel); end
            checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", c, Out_Valid); end
        end
        Out_Ready = 1'b1;
        #1;
        checks++; if (In_Ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", In_Ready); end
        tick();
        checks++; if (Out_Data !== 32'h66) begin errors++; $display("FAIL bp_refill_data got=%h exp=66", Out_Data); end
        checks++; if (Out_Sel !== 2'd1) begin errors++; $display("FAIL bp_refill_sel got=%0d exp=1", Out_Sel); end
    endtask

    task automatic test_mid_reset();
        In_Mode = 1'b1; In_Valid = 4'b0010; Out_Ready = 1'b1;
        set_data(32'h0, 32'h81, 32'h0, 32'h0);
        tick();
        checks++; if (Out_Sel !== 2'd1) begin errors++; $display("FAIL mr_pre_sel got=%0d exp=1", Out_Sel); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid got=%0b exp=0", Out_Valid); end
        checks++; if (In_Ready !== 4'b0000) begin errors++; $display("FAIL mr_in_ready got=%b exp=0000", In_Ready); end
        tick();
        rstn = 1'b1; In_Valid = 4'b1111;
        set_data(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        #1;
        checks++; if (In_Ready !== 4'b0001) begin errors++; $display("FAIL mr_first_grant got=%b exp=0001", In_Ready); end
        tick();
        checks++; if (Out_Sel !== 2'd0) begin errors++; $display("FAIL mr_out_sel got=%0d exp=0", Out_Sel); end
        checks++; if (Out_Data !== 32'hC0) begin errors++; $display("FAIL mr_out_data got=%h exp=c0", Out_Data); end
    endtask

    task automatic test_idle_and_mode_switch();
        In_Valid = 4'b0000;
        #1;
        checks++; if (In_Ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready got=%b exp=0000", In_Ready); end
        tick();
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%0b exp=0", Out_Valid); end
        checks++; if (Out_Data !== 32'hC0) begin errors++; $display("FAIL idle_stale_data got=%h exp=c0", Out_Data); end
        In_Mode = 1'b1; In_Valid = 4'b1001;
        #1;
        checks++; if (In_Ready !== 4'b1000) begin errors++; $display("FAIL ms_rr_grant got=%b exp=1000", In_Ready); end
        In_Mode = 1'b0;
        #1;
        checks++; if (In_Ready !== 4'b0001) begin errors++; $display("FAIL ms_fp_grant got=%b exp=0001", In_Ready); end
        tick();
        checks++; if (Out_Data !== 32'hC0 || Out_Valid !== 1'b1) begin errors++; $display("FAIL ms_out got=%h/%0b exp=c0/1", Out_Data, Out_Valid); end
    endtask

`ifdef ARB_MUX_LOCK_EN
    task automatic test_lock();
        do_reset();
        In_Mode = 1'b0; Out_Ready = 1'b1; In_Valid = 4'b0100; In_Last = 4'b0000;
        set_data(32'hD0, 32'h0, 32'hE0, 32'h0);
        tick();
        checks++; if (Out_Sel !== 2'd2 || Out_Last !== 1'b0) begin errors++; $display("FAIL lk_beat0 sel=%0d last=%0b exp=2/0", Out_Sel, Out_Last); end
        In_Valid = 4'b0101;
        set_data(32'hD0, 32'h0, 32'hE1, 32'h0);
        #1;
        checks++; if (In_Ready !== 4'b0100) begin errors++; $display("FAIL lk_ready got=%b exp=0100", In_Ready); end
        tick();
        checks++; if (Out_Sel !== 2'd2 || Out_Last !== 1'b0 || Out_Data !== 32'hE1) begin errors++; $display("FAIL lk_beat1 sel=%0d last=%0b data=%h exp=2/0/e1", Out_Sel, Out_Last, Out_Data); end
        In_Last = 4'b0100;
        set_data(32'hD0, 32'h0, 32'hE2, 32'h0);
        tick();
        checks++; if (Out_Sel !== 2'd2 || Out_Last !== 1'b1) begin errors++; $display("FAIL lk_beat2 sel=%0d last=%0b exp=2/1", Out_Sel, Out_Last); end
        In_Valid = 4'b0001;
        tick();
        checks++; if (Out_Sel !== 2'd0 || Out_Data !== 32'hD0) begin errors++; $display("FAIL lk_after sel=%0d data=%h exp=0/d0", Out_Sel, Out_Data); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
`ifdef ARB_MUX_LOCK_EN
        In_Last = 4'b1111;
`endif
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_idle_and_mode_switch();
`ifdef ARB_MUX_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
